// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
// Control unit for a shift-free repeated-addition multiplier. It loads operand A
// and then operand B from a shared 16-bit bus. It then runs the product adder
// once per count of B. The B register is an external down-counter, which
// reports zero through eqz.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   start      begin a multiply (honoured only when idle)
//   abort      cancel the operation in progress (ignored when idle)
//   din_valid  operand beat present on the shared data bus
//   din_ready  controller accepts an operand beat (LOAD_A / LOAD_B)
//   eqz        B down-counter is zero
//   p_cout     carry-out of the 16-bit product adder
//   ldA        load operand A register
//   ldB        load B down-counter (also its ld input)
//   ldP        load product register with P + A
//   clrP       clear product register
//   decB       decrement B down-counter
//   busy       registered: in LOAD_A, LOAD_B or ADD
//   done       registered: result available (DONE)
//   ovf        sticky product overflow, cleared by the next accepted start
//   res_ready  consumer accepts the result
//   iter_cnt   number of add iterations performed (saturating)
// -----------------------------------------------------------------------------
module mul_seq_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        din_valid,
   output logic        din_ready,
   input  logic        eqz,
   input  logic        p_cout,
   output logic        ldA,
   output logic        ldB,
   output logic        ldP,
   output logic        clrP,
   output logic        decB,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   input  logic        res_ready,
   output logic [15:0] iter_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      ADD    = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic        busy_r;
   logic        done_r;
   logic        ovf_r;
   logic [15:0] iter_cnt_r;

   logic        abort_s;
   logic        accept_start_s;
   logic        ld_a_s;
   logic        ld_b_s;
   logic        ld_p_s;
   logic        clr_p_s;
   logic        dec_b_s;

   // Abort only has meaning once an operation is under way.
   assign abort_s        = abort && (state_r != IDLE);
   assign accept_start_s = start && (state_r == IDLE);

   // Next-state selection; abort overrides every other transition.
   always_comb begin
      state_nxt_s = state_r;
      if (abort_s) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_nxt_s = start     ? LOAD_A : IDLE;
            LOAD_A:  state_nxt_s = din_valid ? LOAD_B : LOAD_A;
            LOAD_B:  state_nxt_s = din_valid ? ADD    : LOAD_B;
            ADD:     state_nxt_s = eqz       ? DONE   : ADD;
            DONE:    state_nxt_s = res_ready ? IDLE   : DONE;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // Datapath strobes follow the bus and counter handshakes without a cycle of delay.
   always_comb begin
      ld_a_s  = 1'b0;
      ld_b_s  = 1'b0;
      ld_p_s  = 1'b0;
      clr_p_s = 1'b0;
      dec_b_s = 1'b0;
      if (abort_s) begin
         ld_a_s = 1'b0;
      end else begin
         case (state_r)
            LOAD_A: ld_a_s = din_valid;
            LOAD_B: begin
               ld_b_s  = din_valid;
               clr_p_s = din_valid;
            end
            // The last ADD cycle (counter at zero) only retires to DONE.
            ADD: begin
               ld_p_s  = ~eqz;
               dec_b_s = ~eqz;
            end
            default: ld_a_s = 1'b0;
         endcase
      end
   end

   // State register, registered status flags and the iteration/overflow bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ovf_r      <= 1'b0;
         iter_cnt_r <= 16'd0;
      end else begin
         state_r <= state_nxt_s;
         // Status flags are decoded from the state being entered, so they line up with it.
         busy_r  <= (state_nxt_s == LOAD_A) || (state_nxt_s == LOAD_B) || (state_nxt_s == ADD);
         done_r  <= (state_nxt_s == DONE);
         if (accept_start_s) begin
            iter_cnt_r <= 16'd0;
            ovf_r      <= 1'b0;
         end else begin
            // ldP is exactly "an add iteration happened", abort included.
            if (ld_p_s && (iter_cnt_r != 16'hFFFF)) begin
               iter_cnt_r <= iter_cnt_r + 16'd1;
            end else begin
               iter_cnt_r <= iter_cnt_r;
            end
            if (ld_p_s && p_cout) begin
               ovf_r <= 1'b1;
            end else begin
               ovf_r <= ovf_r;
            end
         end
      end
   end

   assign din_ready = (state_r == LOAD_A) || (state_r == LOAD_B);
   assign ldA       = ld_a_s;
   assign ldB       = ld_b_s;
   assign ldP       = ld_p_s;
   assign clrP      = clr_p_s;
   assign decB      = dec_b_s;
   assign busy      = busy_r;
   assign done      = done_r;
   assign ovf       = ovf_r;
   assign iter_cnt  = iter_cnt_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_ctrl
// Directed bench for mul_seq_ctrl. A small model of the external datapath
// (A register, B down-counter, product adder) is driven by the DUT strobes.
// Each multiply pushes its hand-computed result into a scoreboard queue. A
// monitor pops and compares that result when done rises. The driver checks
// cycle-level strobe, handshake and reset behaviour inline.
// -----------------------------------------------------------------------------
module tb_mul_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        din_valid;
   logic        din_ready;
   logic        eqz;
   logic        p_cout;
   logic        ldA;
   logic        ldB;
   logic        ldP;
   logic        clrP;
   logic        decB;
   logic        busy;
   logic        done;
   logic        ovf;
   logic        res_ready;
   logic [15:0] iter_cnt;

   logic [15:0] din;
   logic [15:0] a_r;
   logic [15:0] cnt_r;
   logic [15:0] p_r;
   logic [16:0] sum_s;

   typedef struct {
      logic [15:0] prod;
      logic [15:0] iter;
      logic        ovf;
      int          add_cyc;
      int          ldp_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp;
   int   n_bad;
   int   add_cyc;
   int   ldp_cyc;
   logic prev_done;

   mul_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .eqz       (eqz),
      .p_cout    (p_cout),
      .ldA       (ldA),
      .ldB       (ldB),
      .ldP       (ldP),
      .clrP      (clrP),
      .decB      (decB),
      .busy      (busy),
      .done      (done),
      .ovf       (ovf),
      .res_ready (res_ready),
      .iter_cnt  (iter_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External datapath: operand register, B down-counter and 16-bit product adder.
   always_comb begin
      sum_s  = {1'b0, p_r} + {1'b0, a_r};
      eqz    = (cnt_r == 16'd0);
      p_cout = sum_s[16];
   end

   // Datapath registers updated by the controller strobes.
   always @(posedge clk) begin
      if (ldA)  a_r   <= din;
      if (ldB)  cnt_r <= din;
      if (clrP) p_r   <= 16'd0;
      if (ldP)  p_r   <= sum_s[15:0];
      if (decB) cnt_r <= cnt_r - 16'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: counts ADD cycles and ldP cycles, and scores each result as done rises.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_done = 1'b0;
         add_cyc   = 0;
         ldp_cyc   = 0;
      end else begin
         if (din_ready) begin
            add_cyc = 0;
            ldp_cyc = 0;
         end
         if (busy && !din_ready) add_cyc++;
         if (ldP) ldp_cyc++;
         if (done && !prev_done) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done=1 expected no result at %0t", $time);
            end else begin
               e = sb_q.pop_front();
               check("product",  {16'd0, p_r},      {16'd0, e.prod});
               check("iter_cnt", {16'd0, iter_cnt}, {16'd0, e.iter});
               check("ovf",      {31'd0, ovf},      {31'd0, e.ovf});
               check("add_cyc",  add_cyc,           e.add_cyc);
               check("ldp_cyc",  ldp_cyc,           e.ldp_cyc);
            end
         end
         prev_done = done;
      end
   end

   // One multiply with optional bus stalls and a result-hold phase. Start is
   // held high during the hold phase to show that DONE ignores it.
   task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                          input int stall, input int hold, input exp_t e);
      sb_q.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_iter_clr", {16'd0, iter_cnt}, 32'd0);
      check("start_ovf_clr",  {31'd0, ovf},      32'd0);
      check("load_a_busy",    {31'd0, busy},     32'd1);
      for (int i = 0; i < stall; i++) begin
         #1;
         check("stall_a_ready", {31'd0, din_ready},  32'd1);
         check("stall_a_ld",    {30'd0, ldA, ldB},   32'd0);
         tick();
      end
      din = a;
      din_valid = 1'b1;
      #1;
      check("beat_a_ready",  {31'd0, din_ready},       32'd1);
      check("beat_a_strobe", {29'd0, ldA, ldB, clrP},  32'd4);
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < stall; i++) begin
         #1;
         check("stall_b_ready", {31'd0, din_ready},      32'd1);
         check("stall_b_ld",    {29'd0, ldA, ldB, clrP}, 32'd0);
         tick();
      end
      din = b;
      din_valid = 1'b1;
      #1;
      check("beat_b_strobe", {29'd0, ldA, ldB, clrP}, 32'd3);
      tick();
      din_valid = 1'b0;
      din = 16'hDEAD;
      // First ADD cycle: adds only when B is non-zero.
      check("add0_ready", {31'd0, din_ready},  32'd0);
      check("add0_ldp",   {30'd0, ldP, decB},  (b != 16'd0) ? 32'd3 : 32'd0);
      for (int i = 0; i < 70000 && !done; i++) tick();
      check("done_seen",  {31'd0, done}, 32'd1);
      check("done_busy",  {31'd0, busy}, 32'd0);
      start = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_done", {30'd0, done, busy}, 32'd2);
         check("hold_ready", {31'd0, din_ready}, 32'd0);
      end
      start = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("release_done", {30'd0, done, busy}, 32'd0);
      check("release_iter", {16'd0, iter_cnt}, {16'd0, e.iter});
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      din_valid = 1'b0;
      res_ready = 1'b0;
      din = 16'd0;
      a_r = 16'd0;
      cnt_r = 16'd0;
      p_r = 16'd0;
      #12;
      check("rst_status", {29'd0, busy, done, ovf}, 32'd0);
      check("rst_iter",   {16'd0, iter_cnt},        32'd0);
      check("rst_strobe", {26'd0, din_ready, ldA, ldB, ldP, clrP, decB}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 5 x 3
      run_mul(16'd5, 16'd3, 0, 0, '{16'd15, 16'd3, 1'b0, 4, 3});
      // B = 0: one ADD cycle, no add
      run_mul(16'd9, 16'd0, 0, 0, '{16'd0, 16'd0, 1'b0, 1, 0});
      // bus stalls in both load states
      run_mul(16'd6, 16'd2, 5, 0, '{16'd12, 16'd2, 1'b0, 3, 2});
      // 0x8000 x 2 overflows on the second add
      run_mul(16'h8000, 16'd2, 0, 0, '{16'd0, 16'd2, 1'b1, 3, 2});
      // the next start clears the sticky ovf
      run_mul(16'd2, 16'd4, 0, 0, '{16'd8, 16'd4, 1'b0, 5, 4});

      // Abort in the second ADD cycle: no strobes, back to IDLE, no result.
      start = 1'b1;
      tick();
      start = 1'b0;
      din = 16'd7;
      din_valid = 1'b1;
      tick();
      din = 16'd3;
      tick();
      din_valid = 1'b0;
      tick();
      abort = 1'b1;
      #1;
      check("abort_strobes", {27'd0, ldA, ldB, ldP, clrP, decB}, 32'd0);
      check("abort_busy",    {31'd0, busy}, 32'd1);
      tick();
      abort = 1'b0;
      check("abort_idle",  {29'd0, busy, done, din_ready}, 32'd0);
      check("abort_iter",  {16'd0, iter_cnt}, 32'd1);
      check("abort_ovf",   {31'd0, ovf}, 32'd0);
      tick();
      tick();
      check("abort_no_done", {31'd0, done}, 32'd0);
      run_mul(16'd4, 16'd5, 0, 0, '{16'd20, 16'd5, 1'b0, 6, 5});

      // Reset pulsed between clock edges in the middle of ADD.
      start = 1'b1;
      tick();
      start = 1'b0;
      din = 16'd3;
      din_valid = 1'b1;
      tick();
      din = 16'd6;
      tick();
      din_valid = 1'b0;
      tick();
      tick();
      check("pre_rst_iter", {16'd0, iter_cnt}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_status", {28'd0, busy, done, ovf, din_ready}, 32'd0);
      check("mid_rst_iter",   {16'd0, iter_cnt}, 32'd0);
      check("mid_rst_strobe", {27'd0, ldA, ldB, ldP, clrP, decB}, 32'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check("post_rst_idle", {29'd0, busy, done, din_ready}, 32'd0);
      // fresh run after reset, result held with res_ready low for 4 cycles
      run_mul(16'd3, 16'd3, 0, 4, '{16'd9, 16'd3, 1'b0, 4, 3});

      tick();
      check("sb_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
